// File: rtl/fifo_reader_pkg.sv
// Shared constants and types for the FIFO read-port to valid/ready stream adapter.
package fifo_reader_pkg;

  localparam int FIFO_READ_LATENCY = 1;
  localparam int BUF_DEPTH         = 3;

  typedef logic [1:0] buf_ptr_t;

  // Circular pointer advance: 0 -> 1 -> 2 -> 0
  function automatic buf_ptr_t ptr_next(input buf_ptr_t p);
    return (p == buf_ptr_t'(BUF_DEPTH - 1)) ? buf_ptr_t'(0) : p + buf_ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Three-entry circular output buffer: push at tail, pop at head, occupancy count.
// The caller guarantees no push while full unless a pop happens on the same edge.
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  r_clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  buf_ptr_t              head;
  buf_ptr_t              tail;
  logic [1:0]            occ_q;

  // Storage, pointers and occupancy; push and pop on one edge leave occ unchanged
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      occ_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ptr_next(tail);
      end
      if (pop) begin
        head <= ptr_next(head);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_data = mem[head];
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Turns a FIFO read port with one cycle of read latency into a valid/ready stream.
// Pops are credit-limited so buffered plus in-flight words never exceed the buffer.
// Optional delivered-word counter: define FIFO_READER_WORD_CNT_EN to build it;
// otherwise words_out is tied to zero.
module fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  r_clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [15:0]           words_out
);
  import fifo_reader_pkg::*;

  localparam logic [2:0] CREDIT = 3'(BUF_DEPTH);

  logic       run;
  logic       infl;
  logic [1:0] occ;
  logic       xfer;

  // run holds off pops for one edge after reset release; infl marks a pop whose data lands next edge
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= 1'b0;
      infl <= 1'b0;
    end else begin
      run  <= 1'b1;
      infl <= fifo_re;
    end
  end

  assign fifo_re = run & en & ~fifo_empty & (({1'b0, occ} + {2'b00, infl}) < CREDIT);
  assign m_valid = (occ != 2'd0);
  assign xfer    = m_valid & m_ready;

  fifo_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .r_clk     (r_clk),
    .rst_n     (rst_n),
    .push      (infl),
    .push_data (fifo_q),
    .pop       (xfer),
    .head_data (m_data),
    .occ       (occ)
  );

`ifdef FIFO_READER_WORD_CNT_EN
  logic [15:0] word_cnt;

  // Count delivered words, wrapping naturally at 16 bits
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (xfer) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end

  assign words_out = word_cnt;
`else
  assign words_out = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural FIFO (one cycle read latency).
module tb_fifo_reader;

  logic        r_clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        fifo_empty;
  logic        fifo_re;
  logic [7:0]  fifo_q = 8'h00;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [15:0] words_out;
  logic        empty_force = 1'b0;

  logic [7:0]  fmem [0:1023];
  int          wr_n = 0;
  int          rd_n = 0;

  logic [7:0]  pop_log [$];
  logic [7:0]  out_log [$];
  int          out_cyc [$];
  int          cyc = 0;
  int          pop_cnt = 0;
  int          pend = 0;
  int          occ_viol = 0;
  int          xfer_since_rst = 0;
  int          wo_nz = 0;

  int          n_chk = 0;
  int          n_bad = 0;

  fifo_reader #(
    .DATA_WIDTH (8),
    .BUF_DEPTH  (3)
  ) dut (
    .r_clk      (r_clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .fifo_q     (fifo_q),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .words_out  (words_out)
  );

  always #5 r_clk = ~r_clk;

  assign fifo_empty = (rd_n >= wr_n) || empty_force;

  // FIFO model and stream monitor
  always @(posedge r_clk) begin
    cyc++;
    if (!rst_n) begin
      pend           = 0;
      xfer_since_rst = 0;
    end else begin
      if (fifo_re) begin
        pop_cnt++;
        pend++;
        if (rd_n < wr_n) begin
          fifo_q <= fmem[rd_n];
          pop_log.push_back(fmem[rd_n]);
          rd_n   <= rd_n + 1;
        end
      end
      if (m_valid && m_ready) begin
        out_log.push_back(m_data);
        out_cyc.push_back(cyc);
        pend--;
        xfer_since_rst++;
      end
      assert (pend <= 3) else occ_viol++;
    end
    if (words_out != 16'd0) wo_nz = 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    fmem[wr_n] = w;
    wr_n       = wr_n + 1;
  endtask

  task automatic wait_re(input string tag);
    int n = 0;
    while (!fifo_re && n < 30) begin
      @(negedge r_clk);
      n++;
    end
    chk(tag, {31'd0, fifo_re}, 32'd1);
  endtask

  initial begin
    logic [7:0] exp1 [4];
    int pb;
    int ob;
    int n;
    int seen;
    int pbase;
    int obase;
    int nerr;
    int np;
    int no;

    exp1[0] = 8'h11; exp1[1] = 8'h22; exp1[2] = 8'h33; exp1[3] = 8'h44;

    rst_n   = 1'b0;
    en      = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(exp1[i]);

    // reset state
    #12;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_re",    {31'd0, fifo_re}, 32'd0);
    chk("rst_data",  {24'd0, m_data},  32'd0);
    chk("rst_words", {16'd0, words_out}, 32'd0);

    // four words streamed back to back
    @(negedge r_clk);
    rst_n = 1'b1;
    #1;
    chk("t1_no_re_first_edge", {31'd0, fifo_re}, 32'd0);
    wait_re("t1_wait_re");
    for (int i = 0; i < 4; i++) begin
      chk("t1_re_consec", {31'd0, fifo_re}, 32'd1);
      @(negedge r_clk);
    end
    chk("t1_re_stop", {31'd0, fifo_re}, 32'd0);
    repeat (6) @(negedge r_clk);
    chk("t1_nout", out_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (out_log.size() > i) begin
        chk("t1_data", {24'd0, out_log[i]}, {24'd0, exp1[i]});
        chk("t1_data_consec", out_cyc[i] - out_cyc[0], i);
      end
    end
`ifdef FIFO_READER_WORD_CNT_EN
    chk("t1_words", {16'd0, words_out}, 32'd4);
`else
    chk("t1_words_zero", {16'd0, words_out}, 32'd0);
`endif
    chk("t1_valid_low", {31'd0, m_valid}, 32'd0);

    // backpressure: credit limit of three, head held stable
    m_ready = 1'b0;
    pb = pop_cnt;
    for (int i = 0; i < 6; i++) push_word(8'h61 + 8'(i));
    repeat (8) @(negedge r_clk);
    chk("t2_pops3",    pop_cnt - pb, 32'd3);
    chk("t2_re_low",   {31'd0, fifo_re}, 32'd0);
    chk("t2_valid",    {31'd0, m_valid}, 32'd1);
    chk("t2_head",     {24'd0, m_data}, 32'h61);
    repeat (3) @(negedge r_clk);
    chk("t2_head_stable", {24'd0, m_data}, 32'h61);
    chk("t2_valid_held",  {31'd0, m_valid}, 32'd1);
    chk("t2_pops_held",   pop_cnt - pb, 32'd3);
    ob = out_log.size();
    m_ready = 1'b1;
    n = 0;
    while (out_log.size() < ob + 6 && n < 40) begin
      @(negedge r_clk);
      n++;
    end
    chk("t2_nout", out_log.size() - ob, 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (out_log.size() > ob + i)
        chk("t2_order", {24'd0, out_log[ob+i]}, 32'h61 + i);
    end
    @(negedge r_clk);
    chk("t2_drained", {31'd0, m_valid}, 32'd0);

    // enable dropped right after popping 0xA5; 0xB6 stays in the FIFO
    push_word(8'hA5);
    push_word(8'hB6);
    #1;
    wait_re("t3_wait_re");
    @(negedge r_clk);
    en = 1'b0;
    #1;
    chk("t3_re_off", {31'd0, fifo_re}, 32'd0);
    pb   = pop_cnt;
    seen = 0;
    repeat (6) begin
      @(negedge r_clk);
      if (m_valid && m_data == 8'hA5) seen = 1;
    end
    chk("t3_no_pop",  pop_cnt - pb, 32'd0);
    chk("t3_a5_seen", seen, 32'd1);
    chk("t3_valid_low", {31'd0, m_valid}, 32'd0);
    chk("t3_last_out", {24'd0, out_log[out_log.size()-1]}, 32'hA5);

    // reset with two words buffered (0xB6, 0xC1), both discarded
    en      = 1'b1;
    m_ready = 1'b0;
    push_word(8'hC1);
    repeat (6) @(negedge r_clk);
    chk("t4_valid", {31'd0, m_valid}, 32'd1);
    chk("t4_head",  {24'd0, m_data}, 32'hB6);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("t4_rst_data",  {24'd0, m_data}, 32'd0);
    chk("t4_rst_re",    {31'd0, fifo_re}, 32'd0);
    chk("t4_rst_words", {16'd0, words_out}, 32'd0);
    push_word(8'hD1);
    @(negedge r_clk);
    @(negedge r_clk);
    rst_n = 1'b1;
    pb = pop_cnt;
    #1;
    chk("t4_re_after_rel", {31'd0, fifo_re}, 32'd0);
    @(negedge r_clk);
    chk("t4_no_pop_edge1", pop_cnt - pb, 32'd0);
    @(negedge r_clk);
    chk("t4_pop_edge2", pop_cnt - pb, 32'd1);
    ob = out_log.size();
    m_ready = 1'b1;
    n = 0;
    while (out_log.size() <= ob && n < 20) begin
      @(negedge r_clk);
      n++;
    end
    chk("t4_got_word", {31'd0, out_log.size() > ob}, 32'd1);
    if (out_log.size() > ob)
      chk("t4_first_after_rst", {24'd0, out_log[ob]}, 32'hD1);

    // toggling empty flag with random backpressure
    for (int i = 0; i < 600; i++) push_word(8'($urandom_range(0, 255)));
    pbase = pop_log.size();
    obase = out_log.size();
    repeat (1000) begin
      @(negedge r_clk);
      empty_force = ~empty_force;
      m_ready     = 1'($urandom_range(0, 1));
    end
    @(negedge r_clk);
    en          = 1'b0;
    empty_force = 1'b0;
    m_ready     = 1'b1;
    repeat (10) @(negedge r_clk);
    np = pop_log.size() - pbase;
    no = out_log.size() - obase;
    chk("t5_activity", {31'd0, np > 100}, 32'd1);
    chk("t5_count", no, np);
    nerr = 0;
    for (int i = 0; i < np && i < no; i++) begin
      if (out_log[obase+i] !== pop_log[pbase+i]) nerr++;
    end
    chk("t5_order", nerr, 32'd0);
    chk("t5_drained", {31'd0, m_valid}, 32'd0);
    chk("occ_bound", occ_viol, 32'd0);

    // word counter against transfers since the last reset
    chk("t6_enough_xfers", {31'd0, xfer_since_rst >= 10}, 32'd1);
`ifdef FIFO_READER_WORD_CNT_EN
    chk("t6_words", {16'd0, words_out}, {16'd0, 16'(xfer_since_rst)});
`else
    chk("t6_words_zero", {16'd0, words_out}, 32'd0);
    chk("t6_words_never", wo_nz, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the FIFO word width and stream width (1..16).
REQ-002 SHALL have parameter BUF_DEPTH, default 3, meaning the output buffer entries; fixed at 3, other values unsupported.
REQ-003 r_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  read enable; when low, no new FIFO pops are issued.
REQ-006 fifo_empty  in  1  FIFO empty flag from the FIFO read side.
REQ-007 fifo_re  out  1  FIFO pop strobe.
REQ-008 fifo_q  in  DATA_WIDTH  FIFO read data, valid exactly one r_clk after the fifo_re cycle.
REQ-009 m_valid  out  1  output word valid.
REQ-010 m_ready  in  1  downstream accept.
REQ-011 m_data  out  DATA_WIDTH  output word.
REQ-012 words_out  out  16  delivered-word count (see Configuration).

Function
REQ-013 SHALL convert the 1-cycle-latency FIFO read port into a valid/ready stream, sustaining 1 word per r_clk when the FIFO is non-empty and m_ready is held high.
REQ-014 SHALL track occ (buffered words, 0..3) and infl (1 when a pop was issued last cycle).
REQ-015 fifo_re SHALL = run & en & ~fifo_empty & (occ + infl < 3); it has no combinational dependence on m_ready.
REQ-016 run SHALL be a register cleared by reset and set on the first r_clk edge after rst_n rises.
REQ-017 When infl=1, fifo_q SHALL be written into the buffer tail on that edge, with no condition attached.
REQ-018 m_valid SHALL = (occ != 0); m_data SHALL be the buffer head, with no combinational path from fifo_q.
REQ-019 A transfer occurs on an edge with m_valid & m_ready; the head is removed on that edge.
REQ-020 A simultaneous capture and transfer SHALL leave occ unchanged, with the order of the data preserved.
REQ-021 While m_valid=1 and m_ready=0, m_data SHALL stay stable and m_valid SHALL stay high.
REQ-022 Words SHALL be delivered in pop order, with none dropped or duplicated.
REQ-023 When en falls, pops SHALL stop immediately; the in-flight word and buffered words still drain.
REQ-024 fifo_empty rising while infl=1 SHALL still capture the in-flight word.
REQ-025 occ SHALL never exceed 3; the credit rule of REQ-015 guarantees this, and an overflow is a design error.
REQ-026 The buffer SHALL be circular with 2-bit head and tail pointers that wrap from 2 to 0.

Reset
REQ-027 On rst_n low, the module SHALL asynchronously force occ=0, infl=0, run=0, head=tail=0, m_valid=0, m_data=0, fifo_re=0 and words_out=0.
REQ-028 Reset during operation SHALL discard buffered and in-flight words; these words are lost because the FIFO pointers are not rewound.
REQ-029 No fifo_re SHALL be issued in the first r_clk edge after reset release.

Configuration
REQ-030 Macro FIFO_READER_WORD_CNT_EN defined: words_out SHALL increment by 1 per transfer and wrap from 0xFFFF to 0x0000.
REQ-031 Macro FIFO_READER_WORD_CNT_EN undefined: words_out SHALL be tied to 0 and no counter SHALL be built; the port list SHALL be unchanged.

Structure
REQ-032 A shared package SHALL hold the constants FIFO_READ_LATENCY=1 and BUF_DEPTH=3, and the 2-bit buffer pointer type.
REQ-033 One sub-module, fifo_reader_buf (the 3-entry circular buffer with push, pop, head and occ), SHALL be instantiated once; the credit logic and run stay in fifo_reader.

Verification
REQ-034 The bench SHALL model the FIFO holding 0x11,0x22,0x33,0x44 with m_ready=1 and en=1; required: four fifo_re in consecutive cycles, m_data 0x11..0x44 on four consecutive cycles, words_out=4 (macro on).
REQ-035 With m_ready=0 and 6 words available: exactly 3 pops, occ=3, fifo_re low thereafter, m_data=first word and stable; m_ready then raised: all 6 words delivered in order.
REQ-036 en dropped the cycle after a pop of 0xA5: no further fifo_re; 0xA5 still appears on m_data; m_valid then goes low.
REQ-037 rst_n pulsed low while occ=2: outputs reset immediately; first fifo_re occurs no earlier than the second edge after release; words_out=0.
REQ-038 fifo_empty toggling every cycle with m_ready random for 1000 cycles: output sequence equals the pop sequence, and occ<=3 is checked by assertion.
REQ-039 Macro off, 10 transfers: words_out remains 0 throughout.
